// File: rtl/comp_seq_pkg.sv
// Shared types, constants and the image-window index function for computation_sequencer.
// The index function turns window w and kernel tap k into a flat 4x4 image address.
package comp_seq_pkg;

  localparam int SYS_LAT = 4;
  localparam int CUS_LAT = 2;
  localparam int IDX_W   = 4;
  localparam int W_W     = 2;
  localparam int K_W     = 4;
  localparam int CNT_W   = 4;

  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_SYS    = 2'd2;
  localparam logic [1:0] MODE_CUS    = 2'd3;

  localparam logic [W_W-1:0]   LAST_W         = 2'd3;
  localparam logic [CNT_W-1:0] LAST_TAP       = 4'd8;
  localparam logic [CNT_W-1:0] PE_TAIL_K      = 4'd9;
  localparam logic [CNT_W-1:0] SYS_FIRST_OUT  = CNT_W'(SYS_LAT + 1);
  localparam logic [CNT_W-1:0] SYS_LAST_STEP  = CNT_W'(SYS_LAT + 4);
  localparam logic [CNT_W-1:0] CUS_LAST_PHASE = CNT_W'(CUS_LAT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PE_RUN,
    ST_SYS_LOAD,
    ST_CUS_RUN,
    ST_DONE
  } state_t;

  // Every registered output of the sequencer, so reset and decode handle them as one word.
  typedef struct packed {
    logic                      busy;
    logic                      done;
    logic                      out_valid;
    logic [1:0]                out_idx;
    logic [1:0]                mode;
    logic                      pe_rst;
    logic                      sys_rst;
    logic                      cus_rst;
    logic                      preset;
    logic                      pe_init;
    logic                      cus_init;
    logic                      sys_cache_we_1;
    logic                      sys_cache_we_2;
    logic [IDX_W-1:0]          pe_sel_a;
    logic [IDX_W-1:0]          pe_sel_b;
    logic [IDX_W-1:0]          sys_sel_a;
    logic [IDX_W-1:0]          sys_sel_b;
    logic [8:0][IDX_W-1:0]     cus_sel;
  } ctrl_t;

  function automatic ctrl_t reset_ctrl();
    ctrl_t c;
    c         = '0;
    c.pe_rst  = 1'b1;
    c.sys_rst = 1'b1;
    c.cus_rst = 1'b1;
    c.preset  = 1'b1;
    return c;
  endfunction

  // Row and column both stay within 0..3, so 4*row+col never wraps the 4-bit address.
  function automatic logic [IDX_W-1:0] a_idx(input logic [W_W-1:0] w, input logic [K_W-1:0] k);
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    row = IDX_W'(w[1]) + (k / K_W'(3));
    col = IDX_W'(w[0]) + (k % K_W'(3));
    return IDX_W'((row << 2) + col);
  endfunction

endpackage

// File: rtl/conv_index_gen.sv
// Combinational (window, tap) -> (image index, kernel index) for the single-PE operand path.
module conv_index_gen
  import comp_seq_pkg::*;
(
  input  logic [W_W-1:0]   w,
  input  logic [K_W-1:0]   k,
  output logic [IDX_W-1:0] sel_a,
  output logic [IDX_W-1:0] sel_b
);

  assign sel_a = comp_seq_pkg::a_idx(w, k);
  assign sel_b = IDX_W'(k);

endmodule

// File: rtl/computation_sequencer.sv
// Control sequencer for one 2x2 convolution job over a 4x4 image with a 3x3 kernel.
// Optional `COMP_SEQ_PERF_EN adds a saturating busy-cycle counter on cyc_cnt.
module computation_sequencer
  import comp_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode_req,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic [1:0]       out_idx,
  output logic [1:0]       mode,
  output logic             pe_rst,
  output logic             sys_rst,
  output logic             cus_rst,
  output logic             preset,
  output logic             pe_init,
  output logic             cus_init,
  output logic             sys_cache_we_1,
  output logic             sys_cache_we_2,
  output logic [IDX_W-1:0] pe_sel_a,
  output logic [IDX_W-1:0] pe_sel_b,
  output logic [IDX_W-1:0] sys_sel_a,
  output logic [IDX_W-1:0] sys_sel_b,
  output logic [IDX_W-1:0] cus_sel_11,
  output logic [IDX_W-1:0] cus_sel_12,
  output logic [IDX_W-1:0] cus_sel_13,
  output logic [IDX_W-1:0] cus_sel_21,
  output logic [IDX_W-1:0] cus_sel_22,
  output logic [IDX_W-1:0] cus_sel_23,
  output logic [IDX_W-1:0] cus_sel_31,
  output logic [IDX_W-1:0] cus_sel_32,
  output logic [IDX_W-1:0] cus_sel_33
`ifdef COMP_SEQ_PERF_EN
  ,
  output logic [15:0]      cyc_cnt
`endif
);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [W_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [IDX_W-1:0] pe_a, pe_b;
  logic             accept;

  assign accept = (state_q == ST_IDLE) && start && (mode_req != 2'd0);

  // cnt is the tap k in PE_RUN (9 = tail), the step in SYS_LOAD, the latency phase in CUS_RUN.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    mode_d  = mode_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        mode_d = 2'd0;
        w_d    = '0;
        cnt_d  = '0;
        if (accept) begin
          state_d = ST_CLEAR;
          mode_d  = mode_req;
        end
      end
      ST_CLEAR: begin
        unique case (mode_q)
          MODE_SINGLE: state_d = ST_PE_RUN;
          MODE_SYS:    state_d = ST_SYS_LOAD;
          default:     state_d = ST_CUS_RUN;
        endcase
      end
      ST_PE_RUN: begin
        if (cnt_q == PE_TAIL_K) begin
          state_d = ST_DONE;
        end else if (cnt_q == LAST_TAP && w_q != LAST_W) begin
          cnt_d = '0;
          w_d   = w_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SYS_LOAD: begin
        if (cnt_q == SYS_LAST_STEP) state_d = ST_DONE;
        else                        cnt_d   = cnt_q + 4'd1;
      end
      ST_CUS_RUN: begin
        if (cnt_q == CUS_LAST_PHASE) begin
          cnt_d = '0;
          if (w_q == LAST_W) state_d = ST_DONE;
          else               w_d     = w_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  conv_index_gen u_pe_idx (
    .w     (w_d),
    .k     (cnt_d),
    .sel_a (pe_a),
    .sel_b (pe_b)
  );

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    ctrl_d      = '0;
    ctrl_d.busy = (state_d != ST_IDLE);
    ctrl_d.mode = (state_d == ST_IDLE) ? 2'd0 : mode_d;
    unique case (state_d)
      ST_CLEAR: begin
        ctrl_d.preset  = 1'b1;
        ctrl_d.pe_rst  = (mode_d == MODE_SINGLE);
        ctrl_d.sys_rst = (mode_d == MODE_SYS);
        ctrl_d.cus_rst = (mode_d == MODE_CUS);
      end
      ST_PE_RUN: begin
        if (cnt_d <= LAST_TAP) begin
          ctrl_d.pe_sel_a = pe_a;
          ctrl_d.pe_sel_b = pe_b;
          ctrl_d.pe_init  = (cnt_d == '0);
        end
        if (cnt_d == '0 && w_d != '0) begin
          ctrl_d.out_valid = 1'b1;
          ctrl_d.out_idx   = w_d - 2'd1;
        end
        if (cnt_d == PE_TAIL_K) begin
          ctrl_d.out_valid = 1'b1;
          ctrl_d.out_idx   = LAST_W;
        end
      end
      ST_SYS_LOAD: begin
        ctrl_d.sys_cache_we_1 = (cnt_d == 4'd0);
        ctrl_d.sys_cache_we_2 = (cnt_d == 4'd1);
        if (cnt_d >= SYS_FIRST_OUT) begin
          ctrl_d.out_valid = 1'b1;
          ctrl_d.out_idx   = W_W'(cnt_d - SYS_FIRST_OUT);
          ctrl_d.sys_sel_a = IDX_W'(ctrl_d.out_idx);
        end
      end
      ST_CUS_RUN: begin
        for (int i = 0; i < 9; i++) begin
          ctrl_d.cus_sel[i] = a_idx(w_d, K_W'(i));
        end
        ctrl_d.cus_init = (cnt_d == '0);
        if (cnt_d == CUS_LAST_PHASE) begin
          ctrl_d.out_valid = 1'b1;
          ctrl_d.out_idx   = w_d;
        end
      end
      ST_DONE:  ctrl_d.done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= 2'd0;
      w_q     <= '0;
      cnt_q   <= '0;
      ctrl_q  <= reset_ctrl();
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign busy           = ctrl_q.busy;
  assign done           = ctrl_q.done;
  assign out_valid      = ctrl_q.out_valid;
  assign out_idx        = ctrl_q.out_idx;
  assign mode           = ctrl_q.mode;
  assign pe_rst         = ctrl_q.pe_rst;
  assign sys_rst        = ctrl_q.sys_rst;
  assign cus_rst        = ctrl_q.cus_rst;
  assign preset         = ctrl_q.preset;
  assign pe_init        = ctrl_q.pe_init;
  assign cus_init       = ctrl_q.cus_init;
  assign sys_cache_we_1 = ctrl_q.sys_cache_we_1;
  assign sys_cache_we_2 = ctrl_q.sys_cache_we_2;
  assign pe_sel_a       = ctrl_q.pe_sel_a;
  assign pe_sel_b       = ctrl_q.pe_sel_b;
  assign sys_sel_a      = ctrl_q.sys_sel_a;
  assign sys_sel_b      = ctrl_q.sys_sel_b;
  assign cus_sel_11     = ctrl_q.cus_sel[0];
  assign cus_sel_12     = ctrl_q.cus_sel[1];
  assign cus_sel_13     = ctrl_q.cus_sel[2];
  assign cus_sel_21     = ctrl_q.cus_sel[3];
  assign cus_sel_22     = ctrl_q.cus_sel[4];
  assign cus_sel_23     = ctrl_q.cus_sel[5];
  assign cus_sel_31     = ctrl_q.cus_sel[6];
  assign cus_sel_32     = ctrl_q.cus_sel[7];
  assign cus_sel_33     = ctrl_q.cus_sel[8];

`ifdef COMP_SEQ_PERF_EN
  logic [15:0] cyc_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                               cyc_cnt_q <= '0;
    else if (accept)                          cyc_cnt_q <= '0;
    else if (ctrl_q.busy && cyc_cnt_q != '1)  cyc_cnt_q <= cyc_cnt_q + 16'd1;
  end

  assign cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_computation_sequencer.sv
// Self-checking bench for computation_sequencer: randomized jobs checked cycle by cycle
// against a reference model computed from window/tap arithmetic relative to the START cycle.
module tb_computation_sequencer;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            out_valid;
    logic [1:0]      out_idx;
    logic [1:0]      mode;
    logic            pe_rst;
    logic            sys_rst;
    logic            cus_rst;
    logic            preset;
    logic            pe_init;
    logic            cus_init;
    logic            we_1;
    logic            we_2;
    logic [3:0]      pe_sel_a;
    logic [3:0]      pe_sel_b;
    logic [3:0]      sys_sel_a;
    logic [3:0]      sys_sel_b;
    logic [8:0][3:0] cus_sel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode_req;
  logic       busy, done, out_valid, pe_rst, sys_rst, cus_rst, preset;
  logic       pe_init, cus_init, sys_cache_we_1, sys_cache_we_2;
  logic [1:0] out_idx, mode;
  logic [3:0] pe_sel_a, pe_sel_b, sys_sel_a, sys_sel_b;
  logic [3:0] cus_sel_11, cus_sel_12, cus_sel_13, cus_sel_21, cus_sel_22;
  logic [3:0] cus_sel_23, cus_sel_31, cus_sel_32, cus_sel_33;
`ifdef COMP_SEQ_PERF_EN
  logic [15:0] cyc_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  computation_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode_req       (mode_req),
    .busy           (busy),
    .done           (done),
    .out_valid      (out_valid),
    .out_idx        (out_idx),
    .mode           (mode),
    .pe_rst         (pe_rst),
    .sys_rst        (sys_rst),
    .cus_rst        (cus_rst),
    .preset         (preset),
    .pe_init        (pe_init),
    .cus_init       (cus_init),
    .sys_cache_we_1 (sys_cache_we_1),
    .sys_cache_we_2 (sys_cache_we_2),
    .pe_sel_a       (pe_sel_a),
    .pe_sel_b       (pe_sel_b),
    .sys_sel_a      (sys_sel_a),
    .sys_sel_b      (sys_sel_b),
    .cus_sel_11     (cus_sel_11),
    .cus_sel_12     (cus_sel_12),
    .cus_sel_13     (cus_sel_13),
    .cus_sel_21     (cus_sel_21),
    .cus_sel_22     (cus_sel_22),
    .cus_sel_23     (cus_sel_23),
    .cus_sel_31     (cus_sel_31),
    .cus_sel_32     (cus_sel_32),
    .cus_sel_33     (cus_sel_33)
`ifdef COMP_SEQ_PERF_EN
    ,
    .cyc_cnt        (cyc_cnt)
`endif
  );

  function automatic exp_t observed();
    exp_t o;
    o.busy       = busy;
    o.done       = done;
    o.out_valid  = out_valid;
    o.out_idx    = out_idx;
    o.mode       = mode;
    o.pe_rst     = pe_rst;
    o.sys_rst    = sys_rst;
    o.cus_rst    = cus_rst;
    o.preset     = preset;
    o.pe_init    = pe_init;
    o.cus_init   = cus_init;
    o.we_1       = sys_cache_we_1;
    o.we_2       = sys_cache_we_2;
    o.pe_sel_a   = pe_sel_a;
    o.pe_sel_b   = pe_sel_b;
    o.sys_sel_a  = sys_sel_a;
    o.sys_sel_b  = sys_sel_b;
    o.cus_sel[0] = cus_sel_11;
    o.cus_sel[1] = cus_sel_12;
    o.cus_sel[2] = cus_sel_13;
    o.cus_sel[3] = cus_sel_21;
    o.cus_sel[4] = cus_sel_22;
    o.cus_sel[5] = cus_sel_23;
    o.cus_sel[6] = cus_sel_31;
    o.cus_sel[7] = cus_sel_32;
    o.cus_sel[8] = cus_sel_33;
    return o;
  endfunction

  // Image address of tap k in window w: 4*(wr+kr) + (wc+kc).
  function automatic logic [3:0] a_ref(input int w, input int k);
    return 4'(4 * (w / 2 + k / 3) + (w % 2 + k % 3));
  endfunction

  // Cycle of the DONE pulse, counted from the START cycle (= 0).
  function automatic int job_len(input int m);
    if (m == 1) return 1 + 36 + 1 + 1;
    if (m == 2) return 1 + 2 + (4 - 1) + 4 + 1;
    return 1 + 4 * (2 + 1) + 1;
  endfunction

  function automatic exp_t exp_reset();
    exp_t e;
    e         = '0;
    e.pe_rst  = 1'b1;
    e.sys_rst = 1'b1;
    e.cus_rst = 1'b1;
    e.preset  = 1'b1;
    return e;
  endfunction

  // Expected outputs t cycles after a START with mode m.
  function automatic exp_t model(input int m, input int t);
    exp_t e;
    int   done_t, j, w, k, p;
    e      = '0;
    done_t = job_len(m);
    if (t < 1 || t > done_t) return e;
    e.busy = 1'b1;
    e.mode = 2'(m);
    if (t == 1) begin
      e.preset  = 1'b1;
      e.pe_rst  = (m == 1);
      e.sys_rst = (m == 2);
      e.cus_rst = (m == 3);
    end else if (t == done_t) begin
      e.done = 1'b1;
    end else if (m == 1) begin
      if (t <= 37) begin
        j = t - 2;
        w = j / 9;
        k = j % 9;
        e.pe_sel_a = a_ref(w, k);
        e.pe_sel_b = 4'(k);
        e.pe_init  = (k == 0);
      end
      if (t >= 11 && (t - 11) % 9 == 0) begin
        e.out_valid = 1'b1;
        e.out_idx   = 2'((t - 11) / 9);
      end
    end else if (m == 2) begin
      e.we_1 = (t == 2);
      e.we_2 = (t == 3);
      if (t >= 3 + 4) begin
        w           = t - 7;
        e.out_valid = 1'b1;
        e.out_idx   = 2'(w);
        e.sys_sel_a = 4'(w);
      end
    end else begin
      j = t - 2;
      w = j / 3;
      p = j % 3;
      for (int i = 0; i < 9; i++) e.cus_sel[i] = a_ref(w, i);
      e.cus_init = (p == 0);
      if (p == 2) begin
        e.out_valid = 1'b1;
        e.out_idx   = 2'(w);
      end
    end
    return e;
  endfunction

  // Runs one job from an idle sequencer; extra_t > 0 re-asserts START during that cycle.
  task automatic drive_job(input int m, input int extra_t, input string name);
    int   done_t;
    exp_t e, o;
    done_t = job_len(m);
    @(negedge clk);
    e = model(m, 0);
    o = observed();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL %s_idle t=0: got %h expected %h", name, o, e);
    end
    start    = 1'b1;
    mode_req = 2'(m);
    for (int t = 1; t <= done_t + 1; t++) begin
      @(negedge clk);
      start    = 1'b0;
      mode_req = 2'($urandom_range(0, 3));
      if (t == extra_t) begin
        start    = 1'b1;
        mode_req = 2'($urandom_range(1, 3));
      end
      e = model(m, t);
      o = observed();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s t=%0d: got %h expected %h", name, t, o, e);
      end
`ifdef COMP_SEQ_PERF_EN
      vectors++;
      if (cyc_cnt !== 16'((t <= done_t) ? t - 1 : done_t)) begin
        miscompares++;
        $display("FAIL %s_cyc_cnt t=%0d: got %0d expected %0d", name, t, cyc_cnt,
                 (t <= done_t) ? t - 1 : done_t);
      end
`endif
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o;
    rst_n    = 1'b0;
    start    = 1'b0;
    mode_req = 2'd0;
    repeat (3) begin
      @(negedge clk);
      o = observed();
      vectors++;
      if (o !== exp_reset()) begin
        miscompares++;
        $display("FAIL reset_state: got %h expected %h", o, exp_reset());
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    o = observed();
    vectors++;
    if (o !== exp_t'('0)) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", o, exp_t'('0));
    end
  endtask

  task automatic test_single_pe();
    drive_job(1, 0, "single_pe");
  endtask

  task automatic test_systolic();
    drive_job(2, 0, "systolic");
  endtask

  task automatic test_custom();
    drive_job(3, 0, "custom");
  endtask

  task automatic test_reject();
    exp_t o;
    repeat (4) begin
      @(negedge clk);
      start    = 1'b1;
      mode_req = 2'd0;
      o = observed();
      vectors++;
      if (o !== exp_t'('0)) begin
        miscompares++;
        $display("FAIL reject_mode0: got %h expected %h", o, exp_t'('0));
      end
    end
    @(negedge clk);
    start = 1'b0;
    o = observed();
    vectors++;
    if (o !== exp_t'('0)) begin
      miscompares++;
      $display("FAIL reject_mode0_end: got %h expected %h", o, exp_t'('0));
    end
  endtask

  task automatic test_start_during_job();
    drive_job(1, 15, "start_in_pe_run");
    drive_job(2, int'($urandom_range(1, 10)), "start_in_sys");
    drive_job(3, int'($urandom_range(1, 13)), "start_in_cus");
  endtask

  task automatic test_mid_job_reset();
    exp_t e, o;
    @(negedge clk);
    start    = 1'b1;
    mode_req = 2'd1;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      start = 1'b0;
      e = model(1, t);
      o = observed();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL midreset_run t=%0d: got %h expected %h", t, o, e);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    o = observed();
    vectors++;
    if (o !== exp_reset()) begin
      miscompares++;
      $display("FAIL midreset_abort: got %h expected %h", o, exp_reset());
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      o = observed();
      vectors++;
      if (o !== exp_t'('0)) begin
        miscompares++;
        $display("FAIL midreset_idle: got %h expected %h", o, exp_t'('0));
      end
    end
    drive_job(1, 0, "post_reset_job");
  endtask

  task automatic test_back_to_back();
    int   m, extra;
    exp_t o;
    repeat (12) begin
      m = int'($urandom_range(0, 3));
      if (m == 0) begin
        @(negedge clk);
        start    = 1'b1;
        mode_req = 2'd0;
        @(negedge clk);
        start = 1'b0;
        o = observed();
        vectors++;
        if (o !== exp_t'('0)) begin
          miscompares++;
          $display("FAIL b2b_reject: got %h expected %h", o, exp_t'('0));
        end
      end else begin
        extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, job_len(m) - 1)) : 0;
        drive_job(m, extra, "back_to_back");
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    mode_req = 2'd0;
    test_reset();
    test_single_pe();
    test_systolic();
    test_custom();
    test_reject();
    test_start_during_job();
    test_mid_job_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
